// File: rtl/ws_array_feeder_if.sv
// Host-side handshake bundle for the weight-stationary array feeder:
// one weight-row stream and one activation-vector stream.
interface ws_array_feeder_if #(
    parameter int unsigned D_W  = 8,
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) ();
    logic                w_valid;
    logic                w_ready;
    logic [COLS*D_W-1:0] w_data;
    logic                a_valid;
    logic                a_ready;
    logic [ROWS*D_W-1:0] a_data;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready
    );
endinterface

// File: rtl/ws_array_feeder.sv
// Transmit-side sequencer for a ROWS x COLS weight-stationary PE grid.
// Buffers a weight tile, shifts it down the weight chain, streams skewed
// activations into the rows and flags which bottom-row sums are real results.
module ws_array_feeder #(
    parameter int unsigned D_W  = 8,
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         num_vec,
    ws_array_feeder_if.slave    bus,
    output logic [COLS*D_W-1:0] arr_weight,
    output logic                weight_we,
    output logic [ROWS*D_W-1:0] arr_act,
    output logic [COLS-1:0]     res_valid,
    output logic                busy,
    output logic                done
);
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWFill  = 3'd1;
    localparam logic [2:0] StWShift = 3'd2;
    localparam logic [2:0] StStream = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam int unsigned IW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned VW        = ROWS + COLS;
    localparam logic [15:0] LastRow   = 16'(ROWS - 1);
    localparam logic [15:0] DrainLast = 16'(ROWS + COLS - 1);

    logic [2:0]          state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         num_vec_q, num_vec_d;
    logic [COLS*D_W-1:0] wbuf_q [ROWS];
    logic [COLS*D_W-1:0] wbuf_d [ROWS];
    logic [COLS*D_W-1:0] arr_weight_q, arr_weight_d;
    logic                weight_we_q, weight_we_d;
    logic [VW-1:0]       vld_q, vld_d;

    logic w_fire;
    logic a_fire;

    assign bus.w_ready = (state_q == StWFill);
    assign bus.a_ready = (state_q == StStream) && (cnt_q < num_vec_q);
    assign w_fire      = bus.w_valid && bus.w_ready;
    assign a_fire      = bus.a_valid && bus.a_ready;

    // Job sequencing; cnt_q is reused as beat, shift, accept and drain counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_vec_d = num_vec_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StWFill;
                    cnt_d     = '0;
                    num_vec_d = num_vec;
                end
            end
            StWFill: begin
                if (w_fire) begin
                    if (cnt_q == LastRow) begin
                        state_d = StWShift;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StWShift: begin
                if (cnt_q == LastRow) begin
                    cnt_d   = '0;
                    state_d = (num_vec_q == 16'd0) ? StDone : StStream;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStream: begin
                if (a_fire) begin
                    if (cnt_q + 16'd1 == num_vec_q) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Weight tile capture in arrival order (slot 0 = bottom PE row).
    always_comb begin
        wbuf_d = wbuf_q;
        if (w_fire) begin
            wbuf_d[cnt_q[IW-1:0]] = bus.w_data;
        end
    end

    // Registered weight-chain drive; uses next-state values so slot i lands in shift cycle i.
    always_comb begin
        arr_weight_d = '0;
        weight_we_d  = 1'b0;
        if (state_d == StWShift) begin
            arr_weight_d = wbuf_d[cnt_d[IW-1:0]];
            weight_we_d  = (cnt_d == LastRow);
        end
    end

    // Valid delay line: bit 0 aligns with the row-0 launch, bit ROWS+c with bottom-row column c.
    always_comb begin
        vld_d = {vld_q[VW-2:0], a_fire};
    end

    // Control and weight state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            num_vec_q    <= '0;
            wbuf_q       <= '{default: '0};
            arr_weight_q <= '0;
            weight_we_q  <= 1'b0;
            vld_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            num_vec_q    <= num_vec_d;
            wbuf_q       <= wbuf_d;
            arr_weight_q <= arr_weight_d;
            weight_we_q  <= weight_we_d;
            vld_q        <= vld_d;
        end
    end

    // Per-row activation skew: row r passes through r+1 register stages.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int unsigned SkW = (r + 1) * D_W;

        logic [SkW-1:0] sk_q, sk_d;
        logic [D_W-1:0] lane;

        // Empty slots launch zero so bubbles contribute nothing to the sums.
        always_comb begin
            lane = a_fire ? bus.a_data[r*D_W +: D_W] : '0;
            sk_d = SkW'({sk_q, lane});
        end

        // Skew stage registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                sk_q <= '0;
            end else begin
                sk_q <= sk_d;
            end
        end

        assign arr_act[r*D_W +: D_W] = sk_q[r*D_W +: D_W];
    end

    assign arr_weight = arr_weight_q;
    assign weight_we  = weight_we_q;
    assign res_valid  = vld_q[VW-1:ROWS];
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
endmodule
